// File: rtl/tl_traffic_source.sv
// Transaction-layer traffic source: pushes numbered 12-bit words into four
// ingress FIFOs, one word per lane per cycle, throttled by almost-full.
module tl_traffic_source #(
  parameter int WORDS_PER_LANE = 8,
  parameter int DATA_W         = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [3:0]        lane_en,
  input  logic [3:0]        almost_full,
  output logic [3:0]        push_out,
  output logic [DATA_W-1:0] data_out0,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  output logic [DATA_W-1:0] data_out3,
  output logic              busy,
  output logic              done,
  output logic [9:0]        sent_total
);

  localparam logic [7:0] WPL = 8'(WORDS_PER_LANE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [3:0]        lane_act;
  logic [7:0]        seq [4];
  logic [DATA_W-1:0] data_q [4];
  logic [3:0]        fire;
  logic [9:0]        fire_cnt;
  logic              complete;
  logic              launch;

  // class field scrambles the low seq bits with the lane id
  function automatic logic [DATA_W-1:0] word(
    input logic [1:0] lane,
    input logic [7:0] s
  );
    return {s[1:0] ^ lane, lane, s};
  endfunction

  always_comb begin
    complete = 1'b1;
    for (int n = 0; n < 4; n++) begin
      if (lane_act[n] && seq[n] != WPL)
        complete = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    fire      = '0;
    launch    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start && !stop && lane_en != 4'd0) begin
          state_nxt = S_RUN;
          launch    = 1'b1;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_nxt = S_IDLE;
        end else if (complete) begin
          state_nxt = S_DONE;
        end else begin
          for (int n = 0; n < 4; n++)
            fire[n] = lane_act[n] & ~almost_full[n] & (seq[n] < WPL);
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    fire_cnt = '0;
    for (int n = 0; n < 4; n++)
      fire_cnt = fire_cnt + 10'(fire[n]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      lane_act   <= '0;
      push_out   <= '0;
      sent_total <= '0;
      for (int n = 0; n < 4; n++) begin
        seq[n]    <= '0;
        data_q[n] <= '0;
      end
    end else begin
      state    <= state_nxt;
      push_out <= fire;
      if (launch) begin
        lane_act   <= lane_en;
        sent_total <= '0;
        for (int n = 0; n < 4; n++)
          seq[n] <= '0;
      end else begin
        sent_total <= sent_total + fire_cnt;
        for (int n = 0; n < 4; n++) begin
          if (fire[n]) begin
            seq[n]    <= seq[n] + 8'd1;
            data_q[n] <= word(2'(n), seq[n]);
          end
        end
      end
    end
  end

  assign data_out0 = data_q[0];
  assign data_out1 = data_q[1];
  assign data_out2 = data_q[2];
  assign data_out3 = data_q[3];
  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);

endmodule

// File: tb/tb_tl_traffic_source.sv
// Randomized bench for tl_traffic_source against a per-lane word-count model.
module tb_tl_traffic_source;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic [3:0]  lane_en;
  logic [3:0]  almost_full;
  logic [3:0]  push_out;
  logic [11:0] d0, d1, d2, d3;
  logic        busy;
  logic        done;
  logic [9:0]  sent_total;

  always #5 clk = ~clk;

  tl_traffic_source #(.WORDS_PER_LANE(W), .DATA_W(12)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .lane_en    (lane_en),
    .almost_full(almost_full),
    .push_out   (push_out),
    .data_out0  (d0),
    .data_out1  (d1),
    .data_out2  (d2),
    .data_out3  (d3),
    .busy       (busy),
    .done       (done),
    .sent_total (sent_total)
  );

  int n_chk = 0;
  int n_pass = 0;
  int phase;
  int total;
  int done_cnt;
  int seq [4];
  logic [3:0] act;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int word(input int n, input int s);
    return (((s % 4) ^ n) * 1024) + n * 256 + s;
  endfunction

  function automatic int dat(input int n);
    case (n)
      0: return int'(d0);
      1: return int'(d1);
      2: return int'(d2);
      default: return int'(d3);
    endcase
  endfunction

  task automatic tick();
    logic [3:0] af_p, en_p, fire;
    logic st_p, sp_p, rs_p, fin, exp_done;
    af_p = almost_full;
    en_p = lane_en;
    st_p = start;
    sp_p = stop;
    rs_p = reset;
    @(negedge clk);
    fire = '0;
    exp_done = 1'b0;
    if (rs_p) begin
      phase = 0; act = '0; total = 0;
      for (int n = 0; n < 4; n++) seq[n] = 0;
    end else if (phase == 0) begin
      if (st_p && !sp_p && en_p != 4'd0) begin
        phase = 1; act = en_p; total = 0;
        for (int n = 0; n < 4; n++) seq[n] = 0;
      end
    end else if (phase == 2) begin
      phase = 0;
    end else if (sp_p) begin
      phase = 0;
    end else begin
      fin = 1'b1;
      for (int n = 0; n < 4; n++)
        if (act[n] && seq[n] < W) fin = 1'b0;
      if (fin) begin
        phase = 2; exp_done = 1'b1;
      end else begin
        for (int n = 0; n < 4; n++) begin
          if (act[n] && !af_p[n] && seq[n] < W) begin
            fire[n] = 1'b1;
            check($sformatf("data%0d", n), dat(n), word(n, seq[n]));
            seq[n]++;
            total++;
          end
        end
      end
    end
    check("push", int'(push_out), int'(fire));
    check("busy", int'(busy), int'(phase == 1));
    check("done", int'(done), int'(exp_done));
    check("total", int'(sent_total), total);
    if (rs_p)
      for (int n = 0; n < 4; n++)
        check($sformatf("rst_data%0d", n), dat(n), 0);
    if (done) done_cnt++;
  endtask

  task automatic run_idle(input int budget, input int af_pct,
                          input int stop_pct, input int start_pct);
    int k = 0;
    while (phase != 0 && k < budget) begin
      for (int n = 0; n < 4; n++)
        almost_full[n] = ($urandom_range(99) < af_pct);
      stop    = ($urandom_range(99) < stop_pct);
      start   = ($urandom_range(99) < start_pct);
      lane_en = 4'($urandom_range(15));
      tick();
      k++;
    end
    check("timeout", phase, 0);
    almost_full = '0;
    stop = 1'b0;
    start = 1'b0;
  endtask

  task automatic launch(input logic [3:0] en);
    lane_en = en;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    lane_en = '0; almost_full = '0;
    phase = 0; total = 0; done_cnt = 0; act = '0;
    for (int n = 0; n < 4; n++) seq[n] = 0;
    @(negedge clk);
    tick();
    tick();
    reset = 1'b0;

    done_cnt = 0;
    launch(4'hF);
    run_idle(40, 0, 0, 0);
    check("t1_total", int'(sent_total), 32);
    check("t1_done", done_cnt, 1);

    done_cnt = 0;
    launch(4'b0101);
    tick();
    tick();
    almost_full = 4'b0001;
    repeat (3) tick();
    almost_full = '0;
    run_idle(40, 0, 0, 0);
    check("t2_total", int'(sent_total), 16);
    check("t2_seq0", seq[0], W);
    check("t2_seq2", seq[2], W);

    done_cnt = 0;
    launch(4'h1);
    for (int k = 0; k < 20 && seq[0] < 3; k++) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    check("t3_total", int'(sent_total), 3);
    check("t3_busy", int'(busy), 0);
    check("t3_done", done_cnt, 0);

    lane_en = 4'hF; start = 1'b1; stop = 1'b1;
    tick();
    check("t4_startstop", int'(busy), 0);
    stop = 1'b0; lane_en = 4'h0;
    tick();
    check("t4_noen", int'(busy), 0);
    start = 1'b0;
    done_cnt = 0;
    launch(4'hF);
    tick();
    tick();
    lane_en = 4'h1; start = 1'b1;
    tick();
    start = 1'b0;
    run_idle(40, 0, 0, 0);
    check("t4_total", int'(sent_total), 32);
    check("t4_done", done_cnt, 1);

    done_cnt = 0;
    launch(4'hF);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_rst_push", int'(push_out), 0);
    check("t5_rst_total", int'(sent_total), 0);
    launch(4'b0011);
    run_idle(40, 0, 0, 0);
    check("t5_total", int'(sent_total), 16);
    check("t5_done", done_cnt, 1);

    for (int r = 0; r < 40; r++) begin
      launch(4'($urandom_range(1, 15)));
      run_idle(400, 40, (r % 3 == 0) ? 3 : 0, 5);
      repeat (2) tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule
